conv_encoder: RTL

Rate-1/2, K=7 convolutional encoder with 802.11a puncturing (1/2, 2/3, 3/4). It sits directly downstream of the scrambler and consumes its serial bit stream, valid-qualified. It emits one coded bit per clock, valid-qualified, toward the interleaver. Coded output outpaces scrambled input, so the block back-pressures its upstream with a ready signal.

---
 rtl/conv_encoder.sv | 120 ++++++++++++
 1 files changed

// File: rtl/conv_encoder.sv
// conv_encoder: K=7 rate-1/2 convolutional encoder (g0=133, g1=171) with 802.11a puncturing under CONVENC_PUNCTURE_EN.
// Latency: first kept bit of a transfer on DataOUT one edge after the transfer, the second kept bit one edge later.
// Backpressure: READY is low while the 2-entry output buffer is full; it is derived from registers only, never from VALID.
module conv_encoder (
  input  logic       clock,
  input  logic       ConvEncoder_Reset,
  input  logic [1:0] ConvEncoder_Rate,
  input  logic       ConvEncoder_DataIN,
  input  logic       ConvEncoder_DataIN_VALID,
  output logic       ConvEncoder_DataIN_READY,
  output logic       ConvEncoder_DataOUT,
  output logic       ConvEncoder_DataOUTVALID
);

  logic [5:0] history;     // history[k-1] holds x(-k)
  logic [1:0] bufBits;     // bufBits[0] is the head of the holding buffer
  logic [1:0] bufCnt;
  logic       transfer;
  logic       codeA;
  logic       codeB;
  logic [1:0] keepCnt;
  logic       keepFirst;
  logic       keepSecond;
  logic [1:0] remCnt;
  logic [1:0] nextBits;
  logic [1:0] nextCnt;

  assign ConvEncoder_DataIN_READY = (bufCnt != 2'd2);
  assign transfer = ConvEncoder_DataIN_VALID & ConvEncoder_DataIN_READY;
  assign codeA = ConvEncoder_DataIN ^ history[1] ^ history[2] ^ history[4] ^ history[5];
  assign codeB = ConvEncoder_DataIN ^ history[0] ^ history[1] ^ history[2] ^ history[5];

`ifdef CONVENC_PUNCTURE_EN
  logic [1:0] phase;
  logic [1:0] latchedRate;
  logic [1:0] reqRate;
  logic [1:0] activeRate;
  logic [1:0] lastPhase;

  // Code 11 behaves as rate 1/2; the rate only takes effect at phase 0
  assign reqRate    = (ConvEncoder_Rate == 2'b11) ? 2'b00 : ConvEncoder_Rate;
  assign activeRate = (phase == 2'd0) ? reqRate : latchedRate;

  // Select which generator outputs survive puncturing at the current phase
  always_comb begin
    keepCnt    = 2'd2;
    keepFirst  = codeA;
    keepSecond = codeB;
    lastPhase  = 2'd0;
    case (activeRate)
      2'b01: begin
        lastPhase = 2'd1;
        if (phase == 2'd1) keepCnt = 2'd1;
      end
      2'b10: begin
        lastPhase = 2'd2;
        if (phase == 2'd1) begin
          keepCnt = 2'd1;
        end else if (phase == 2'd2) begin
          keepCnt   = 2'd1;
          keepFirst = codeB;
        end
      end
      default: ;
    endcase
  end

  // Advance the puncture phase per transfer and capture the rate at each period start
  always_ff @(posedge clock or posedge ConvEncoder_Reset) begin
    if (ConvEncoder_Reset) begin
      phase       <= 2'd0;
      latchedRate <= 2'b00;
    end else if (transfer) begin
      phase <= (phase == lastPhase) ? 2'd0 : phase + 2'd1;
      if (phase == 2'd0) latchedRate <= reqRate;
    end
  end
`else
  // Without puncturing every transfer emits A then B and the rate input is ignored
  logic rateUnused;
  assign rateUnused = ^ConvEncoder_Rate;
  assign keepCnt    = 2'd2;
  assign keepFirst  = codeA;
  assign keepSecond = codeB;
`endif

  // Pop the head first, then append this transfer's kept bits behind what remains
  always_comb begin
    remCnt   = (bufCnt == 2'd0) ? 2'd0 : bufCnt - 2'd1;
    nextBits = {1'b0, bufBits[1]};
    nextCnt  = remCnt;
    if (transfer) begin
      nextCnt = remCnt + keepCnt;
      if (remCnt == 2'd0) nextBits = {keepSecond, keepFirst};
      else                nextBits = {keepFirst, bufBits[1]};
    end
  end

  // Register the output bit, the holding buffer and the encoder history
  always_ff @(posedge clock or posedge ConvEncoder_Reset) begin
    if (ConvEncoder_Reset) begin
      history                  <= 6'd0;
      bufBits                  <= 2'b00;
      bufCnt                   <= 2'd0;
      ConvEncoder_DataOUT      <= 1'b0;
      ConvEncoder_DataOUTVALID <= 1'b0;
    end else begin
      if (bufCnt != 2'd0) begin
        ConvEncoder_DataOUT      <= bufBits[0];
        ConvEncoder_DataOUTVALID <= 1'b1;
      end else begin
        ConvEncoder_DataOUTVALID <= 1'b0;
      end
      bufBits <= nextBits;
      bufCnt  <= nextCnt;
      if (transfer) history <= {history[4:0], ConvEncoder_DataIN};
    end
  end

endmodule
